// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the count controls and the slave (the counter) returns count and flags.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 32'd8
) ();
  logic             clear;
  logic             enable;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output clear, enable, up_dn, load, load_val,
    input  count, tc, wrap, ovf
  );

  modport slave (
    input  clear, enable, up_dn, load, load_val,
    output count, tc, wrap, ovf
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with parallel load, synchronous clear,
// wrap-or-saturate limit handling, a terminal-count flag and wrap/overflow event flags.
module mod_updown_counter #(
  parameter int unsigned     WIDTH     = 32'd8,
  parameter longint unsigned MODULUS   = 64'd256,
  parameter bit              SATURATE  = 1'b0,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  mod_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

  if ((RESET_VAL >= MODULUS) || (MODULUS > (64'd1 << WIDTH)) || (MODULUS < 64'd2)) begin : g_param_err
    $fatal(1, "mod_updown_counter: illegal MODULUS/RESET_VAL for WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max;
  logic             at_zero;
  logic             load_big;

  // Limits are compared against MODULUS-1, so count never passes through values >= MODULUS.
  assign at_max   = (count_q == MAX_C);
  assign at_zero  = (count_q == ZERO_C);
  assign load_big = (64'(bus.load_val) >= MODULUS);

  // Next-state: clear beats load beats enable; wrap is a single-cycle event.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      count_d = RST_C;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      if (load_big) begin
        count_d = MAX_C;
        ovf_d   = 1'b1;
      end else begin
        count_d = bus.load_val;
      end
    end else if (bus.enable) begin
      if (bus.up_dn) begin
        if (at_max) begin
          count_d = SATURATE ? count_q : ZERO_C;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + ONE_C;
        end
      end else begin
        if (at_zero) begin
          count_d = SATURATE ? count_q : MAX_C;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Terminal count follows direction with no register stage.
  always_comb begin
    if (bus.up_dn) begin
      bus.tc = at_max;
    end else begin
      bus.tc = at_zero;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: three configurations share one stimulus stream,
// a modular-arithmetic reference model predicts each edge, and a monitor compares every cycle.
module tb_mod_updown_counter;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       wrap;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       load;
  logic       enable;
  logic       up_dn;
  logic [7:0] lv;

  int n_cmp = 0;
  int n_bad = 0;

  int mod_c [3] = '{10, 10, 200};
  bit sat_c [3] = '{1'b0, 1'b1, 1'b0};
  int rv_c  [3] = '{0, 0, 7};
  int wd_c  [3] = '{4, 4, 8};

  int mc [3];
  bit mo [3];
  bit mw [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  mod_updown_counter_if #(.WIDTH(32'd4)) i0 ();
  mod_updown_counter_if #(.WIDTH(32'd4)) i1 ();
  mod_updown_counter_if #(.WIDTH(32'd8)) i2 ();

  assign i0.clear = clear;  assign i0.load = load;  assign i0.enable = enable;
  assign i0.up_dn = up_dn;  assign i0.load_val = lv[3:0];
  assign i1.clear = clear;  assign i1.load = load;  assign i1.enable = enable;
  assign i1.up_dn = up_dn;  assign i1.load_val = lv[3:0];
  assign i2.clear = clear;  assign i2.load = load;  assign i2.enable = enable;
  assign i2.up_dn = up_dn;  assign i2.load_val = lv;

  mod_updown_counter #(.WIDTH(32'd4), .MODULUS(64'd10), .SATURATE(1'b0), .RESET_VAL(64'd0))
    dut0 (.clk(clk), .reset(reset), .bus(i0));
  mod_updown_counter #(.WIDTH(32'd4), .MODULUS(64'd10), .SATURATE(1'b1), .RESET_VAL(64'd0))
    dut1 (.clk(clk), .reset(reset), .bus(i1));
  mod_updown_counter #(.WIDTH(32'd8), .MODULUS(64'd200), .SATURATE(1'b0), .RESET_VAL(64'd7))
    dut2 (.clk(clk), .reset(reset), .bus(i2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, d, $time, act, exp);
    end
  endtask

  function automatic exp_t actual(input int d);
    exp_t a;
    case (d)
      0: a = '{count: {4'd0, i0.count}, tc: i0.tc, wrap: i0.wrap, ovf: i0.ovf};
      1: a = '{count: {4'd0, i1.count}, tc: i1.tc, wrap: i1.wrap, ovf: i1.ovf};
      default: a = '{count: i2.count, tc: i2.tc, wrap: i2.wrap, ovf: i2.ovf};
    endcase
    return a;
  endfunction

  task automatic check(input int d, input exp_t e);
    exp_t a;
    a = actual(d);
    cmp("count", d, 32'(a.count), 32'(e.count));
    cmp("tc",    d, 32'(a.tc),    32'(e.tc));
    cmp("wrap",  d, 32'(a.wrap),  32'(e.wrap));
    cmp("ovf",   d, 32'(a.ovf),   32'(e.ovf));
  endtask

  // Reference model: one clock edge of a modulo-m counter described arithmetically.
  task automatic model_edge(input int d);
    int m;
    int c;
    int v;
    bit ev;
    m = mod_c[d];
    c = mc[d];
    if (clear) begin
      mc[d] = rv_c[d]; mo[d] = 1'b0; mw[d] = 1'b0;
    end else if (load) begin
      v = int'(lv) % (1 << wd_c[d]);
      mw[d] = 1'b0;
      if (v >= m) begin mc[d] = m - 1; mo[d] = 1'b1; end
      else mc[d] = v;
    end else if (enable) begin
      ev = up_dn ? (c == m - 1) : (c == 0);
      mw[d] = ev;
      if (ev) mo[d] = 1'b1;
      if (!(ev && sat_c[d])) mc[d] = (c + (up_dn ? 1 : m - 1)) % m;
    end else begin
      mw[d] = 1'b0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e.count = 8'(mc[d]);
      e.tc    = up_dn ? (mc[d] == mod_c[d] - 1) : (mc[d] == 0);
      e.wrap  = mw[d];
      e.ovf   = mo[d];
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic step(input bit c, input bit l, input bit e, input bit u, input logic [7:0] v);
    @(negedge clk);
    #1;
    reset = 1'b0;
    clear = c; load = l; enable = e; up_dn = u; lv = v;
    for (int d = 0; d < 3; d++) model_edge(d);
    push_exp();
  endtask

  // Reset is raised mid-cycle; count must drop before the next rising edge.
  task automatic do_reset();
    exp_t a;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      a = actual(d);
      cmp("async_reset_count", d, 32'(a.count), 32'(rv_c[d]));
      cmp("async_reset_ovf",   d, 32'(a.ovf),   32'd0);
      mc[d] = rv_c[d]; mo[d] = 1'b0; mw[d] = 1'b0;
    end
    push_exp();
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest predicted state.
  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front());
    if (q1.size() > 0) check(1, q1.pop_front());
    if (q2.size() > 0) check(2, q2.pop_front());
  end

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; enable = 1'b0; up_dn = 1'b0; lv = 8'd0;
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    // Count up 12 edges through the upper limit.
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    // Load 2 and count down through zero.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    // Clear, then approach the top from 8 and keep pushing.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd8);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    // Priority among clear, load and enable, then an out-of-range load.
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'd5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd12);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd210);
    // Direction flips every edge from 4.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd4);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, (k % 2) == 0, 8'd0);
    // tc must follow up_dn without an edge at the limits.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    // Reset arriving mid-count at 37.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd36);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      else step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    @(negedge clk);
    cmp("queue_drained", 0, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
